fdtd_probe_capture: RTL and testbench
=====================================

// Module: fdtd_probe_capture
// PURPOSE
// Observation-point reader for the FDTD Ez update pipeline. Consumes the updated Ez samples
// that the source/update stage writes at the probe cell, decimates them in time and buffers
// them in a FIFO. The host drains the FIFO through a simple read port. One capture run is
// armed by start and stops after a programmed number of time steps.
// PARAMETERS
// FDTD_DATA_WIDTH  32  width of Ez samples (signed fixed point, passed through unchanged)
// FIFO_DEPTH       64  capture FIFO entries; power of two, >=2
// DECIM_WIDTH      8   width of cfg_decim
// CNT_WIDTH        16  width of cfg_num and the internal step counter
// PORTS
// CLK         in   1      clock
// RST         in   1      synchronous reset, active high
// clken       in   1      pipeline enable; a sample is accepted only when clken && ez_valid
// Ez_n_i      in   FDTD_DATA_WIDTH  updated Ez at probe cell (signed)
// ez_valid    in   1      Ez_n_i holds this time step's probe value
// start       in   1      1-cycle pulse: latch cfg_*, begin a capture run
// abort       in   1      1-cycle pulse: stop capture immediately
// cfg_decim   in   DECIM_WIDTH  keep 1 of every cfg_decim samples (0 treated as 1)
// cfg_num     in   CNT_WIDTH    accepted time steps per run (kept plus skipped)
// rd_en       in   1      host read request
// rd_data     out  FDTD_DATA_WIDTH  FIFO head, registered
// rd_valid    out  1      rd_data valid this cycle (1-cycle pulse per read)
// fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// busy        out  1      FSM in CAPTURE
// done        out  1      FSM in DONE
// overflow    out  1      sticky: a kept sample was dropped because the FIFO was full
// BEHAVIOUR
// - Reset: FSM=IDLE; FIFO empty; rd_data=0, rd_valid=0, fifo_count=0, busy=0, done=0,
//   overflow=0. Reset during a run discards all FIFO contents.
// - FSM is IDLE -> CAPTURE -> DONE.
//   - IDLE: start -> CAPTURE. On entry, latch cfg_decim/cfg_num, set step_cnt=0 and
//     decim_cnt=0, clear overflow. The FIFO is not flushed.
//   - If the latched cfg_num==0, go CAPTURE -> DONE on the next cycle with no sample kept.
//   - CAPTURE: each accepted sample increments step_cnt.
//     - If decim_cnt==0, the sample is kept (FIFO write) and decim_cnt reloads to
//       max(cfg_decim,1)-1. Otherwise decim_cnt decrements and the sample is skipped.
//     - When the step_cnt increment reaches the latched cfg_num -> DONE, on the same edge
//       as the last sample is written.
//     - start while in CAPTURE is ignored.
//   - DONE: done=1 is held. start -> CAPTURE (new run); abort -> IDLE.
//   - abort in any state -> IDLE next cycle. FIFO contents and overflow are retained.
//     A sample accepted in the abort cycle is discarded.
//   - Simultaneous start and abort: abort wins.
// - Write rule: the full check uses occupancy before the edge. A kept sample while full is
//   dropped even if rd_en pops in the same cycle. The drop sets overflow, and step_cnt
//   still advances so the run always terminates.
// - Read: rd_en with FIFO not empty in cycle N gives rd_data=head and rd_valid=1 in N+1,
//   and the pointer advances.
//   - rd_en while empty: rd_valid=0 and rd_data holds its previous value.
//   - No write-to-read bypass: a write into an empty FIFO is readable from the next cycle.
//   - Simultaneous write and read when not full or empty: fifo_count unchanged.
// - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
// - Data is stored bit-exact; no truncation or saturation.
// - The read port is independent of clken; only sample acceptance is gated by clken.
// TESTING
// - cfg_decim=1, cfg_num=5, Ez = -3,7,100,-1,0 on 5 valid cycles
//   -> fifo_count=5, done=1, reads return exactly -3,7,100,-1,0 with 1-cycle latency.
// - cfg_decim=3, cfg_num=10, Ez=0..9 -> FIFO holds 0,3,6,9; busy falls after sample 9.
// - FIFO_DEPTH=64, cfg_decim=1, cfg_num=70, no reads
//   -> fifo_count=64, overflow=1, done=1; reads return samples 0..63.
// - ez_valid=1 with clken=0 for 4 cycles during CAPTURE -> step_cnt and FIFO unchanged.
// - Abort after 3 of cfg_num=8 kept samples -> IDLE, fifo_count=3. A following start with
//   cfg_num=2 -> fifo_count=5, overflow=0.
// - Full FIFO with rd_en and a kept sample in the same cycle -> sample dropped, overflow=1,
//   fifo_count=63. rd_en on empty -> rd_valid=0.

Source files
------------

// File: rtl/fdtd_probe_capture.sv
// Probe-cell Ez capture: decimates accepted samples into a FIFO; host reads with 1-cycle latency.
// No backpressure upstream: kept samples arriving at a full FIFO are dropped and flagged in overflow.
module fdtd_probe_capture #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 64,
    parameter int DECIM_WIDTH     = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         clken,
    input  logic [FDTD_DATA_WIDTH-1:0]   Ez_n_i,
    input  logic                         ez_valid,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DECIM_WIDTH-1:0]       cfg_decim,
    input  logic [CNT_WIDTH-1:0]         cfg_num,
    input  logic                         rd_en,
    output logic [FDTD_DATA_WIDTH-1:0]   rd_data,
    output logic                         rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]          PTR_ONE  = 1;
    localparam logic [CW-1:0]          CNT_ONE  = 1;
    localparam logic [CW-1:0]          FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]   STEP_ONE = 1;
    localparam logic [DECIM_WIDTH-1:0] DEC_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t                     state_q;
    logic                       busy_q, done_q, overflow_q;
    logic [DECIM_WIDTH-1:0]     decim_q, decim_cnt_q;
    logic [CNT_WIDTH-1:0]       num_q, step_cnt_q;

    logic [FDTD_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic [FDTD_DATA_WIDTH-1:0] rd_data_q;
    logic                       rd_valid_q;

    logic                       full_d, accept_d, keep_d, wr_fire_d, drop_d, rd_fire_d, last_d;
    logic [CNT_WIDTH-1:0]       step_d;
    logic [DECIM_WIDTH-1:0]     reload_d;

    // Full is judged on pre-edge occupancy, so a same-cycle pop never frees room for a write.
    assign full_d    = (count_q == FULL_CNT);
    assign accept_d  = (state_q == S_CAPTURE) && !abort && (num_q != '0) && clken && ez_valid;
    assign keep_d    = accept_d && (decim_cnt_q == '0);
    assign wr_fire_d = keep_d && !full_d;
    assign drop_d    = keep_d && full_d;
    assign rd_fire_d = rd_en && (count_q != '0);
    assign step_d    = step_cnt_q + STEP_ONE;
    assign last_d    = accept_d && (step_d == num_q);
    assign reload_d  = (decim_q == '0) ? '0 : decim_q - DEC_ONE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            decim_q     <= '0;
            num_q       <= '0;
            decim_cnt_q <= '0;
            step_cnt_q  <= '0;
        end else if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_CAPTURE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        overflow_q  <= 1'b0;
                        decim_q     <= cfg_decim;
                        num_q       <= cfg_num;
                        decim_cnt_q <= '0;
                        step_cnt_q  <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (num_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (accept_d) begin
                        step_cnt_q  <= step_d;
                        decim_cnt_q <= keep_d ? reload_d : decim_cnt_q - DEC_ONE;
                        if (drop_d)
                            overflow_q <= 1'b1;
                        if (last_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_fire_d)
            mem_q[wr_ptr_q] <= Ez_n_i;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire_d;
            if (rd_fire_d) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            end
            if (wr_fire_d)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (wr_fire_d && !rd_fire_d)
                count_q <= count_q + CNT_ONE;
            else if (rd_fire_d && !wr_fire_d)
                count_q <= count_q - CNT_ONE;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_fdtd_probe_capture.sv
// Bench for fdtd_probe_capture: directed scenarios plus randomized runs against a queue-based model.
module tb_fdtd_probe_capture;
    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        clken = 1'b0;
    logic [31:0] Ez_n_i = '0;
    logic        ez_valid = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_decim = '0;
    logic [15:0] cfg_num = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [6:0]  fifo_count;
    logic        busy, done, overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: run mode (0 idle, 1 capture, 2 done), step index, queue of stored samples.
    int          m_mode = 0;
    int          m_step = 0;
    int          m_num = 0;
    int          m_decim = 0;
    logic [31:0] m_q[$];
    bit          m_ovf = 0;
    bit          m_rv = 0;
    logic [31:0] m_rd = '0;

    fdtd_probe_capture dut (
        .CLK(CLK), .RST(RST), .clken(clken), .Ez_n_i(Ez_n_i), .ez_valid(ez_valid),
        .start(start), .abort(abort), .cfg_decim(cfg_decim), .cfg_num(cfg_num),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance model by one clock using the inputs currently applied, then step the DUT.
    task automatic tick();
        int sz;
        int d;
        bit full;
        bit rd_ok;
        bit keep;
        keep = 0;
        if (RST) begin
            m_mode = 0; m_q.delete(); m_ovf = 0; m_rv = 0; m_rd = '0;
        end else begin
            sz    = m_q.size();
            full  = (sz == DEPTH);
            rd_ok = rd_en && (sz > 0);
            m_rv  = rd_ok;
            if (rd_ok) m_rd = m_q[0];
            if (abort) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                if (m_num == 0) begin
                    m_mode = 2;
                end else if (clken && ez_valid) begin
                    d = (m_decim == 0) ? 1 : m_decim;
                    if (m_step % d == 0) begin
                        if (full) m_ovf = 1;
                        else keep = 1;
                    end
                    m_step++;
                    if (m_step == m_num) m_mode = 2;
                end
            end else if (start) begin
                m_mode = 1; m_num = cfg_num; m_decim = cfg_decim; m_step = 0; m_ovf = 0;
            end
            if (rd_ok) void'(m_q.pop_front());
            if (keep) m_q.push_back(Ez_n_i);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        start = 0; abort = 0; ez_valid = 0; clken = 0; rd_en = 0;
    endtask

    task automatic begin_run(input int decim, input int num);
        cfg_decim = 8'(decim); cfg_num = 16'(num);
        start = 1; tick(); start = 0;
    endtask

    task automatic test_reset();
        quiet();
        RST = 1; tick(); tick(); RST = 0;
        n_cmp++; if (fifo_count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d need 0", fifo_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b need 0", overflow); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b need 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd: got %0h need 0", rd_data); end
    endtask

    task automatic test_basic();
        logic [31:0] vals [5];
        vals = '{-32'sd3, 32'sd7, 32'sd100, -32'sd1, 32'sd0};
        quiet();
        begin_run(1, 5);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b need 1", busy); end
        clken = 1; ez_valid = 1;
        for (int i = 0; i < 5; i++) begin Ez_n_i = vals[i]; tick(); end
        quiet();
        n_cmp++; if (fifo_count !== 7'd5) begin n_err++; $display("FAIL basic_count: got %0d need 5", fifo_count); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b need 1", done); end
        for (int i = 0; i < 5; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== vals[i])
                begin n_err++; $display("FAIL basic_read%0d: got v=%b %0h need v=1 %0h", i, rd_valid, rd_data, vals[i]); end
        end
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_rv_pulse: got %b need 0", rd_valid); end
        rd_en = 1; tick(); rd_en = 0;
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd0)
            begin n_err++; $display("FAIL basic_empty_read: got v=%b %0h need v=0 0", rd_valid, rd_data); end
    endtask

    task automatic test_decim();
        quiet();
        begin_run(3, 10);
        clken = 1;
        for (int i = 0; i < 10; i++) begin
            ez_valid = 1; Ez_n_i = 32'(i); tick();
            n_cmp++; if (busy !== (i < 9)) begin n_err++; $display("FAIL decim_busy%0d: got %b need %b", i, busy, i < 9); end
        end
        quiet();
        n_cmp++; if (fifo_count !== 7'd4) begin n_err++; $display("FAIL decim_count: got %0d need 4", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            n_cmp++; if (rd_data !== 32'(3 * i)) begin n_err++; $display("FAIL decim_read%0d: got %0d need %0d", i, rd_data, 3 * i); end
        end
    endtask

    task automatic test_clken();
        quiet();
        begin_run(1, 6);
        clken = 1; ez_valid = 1;
        for (int i = 0; i < 2; i++) begin Ez_n_i = 32'(50 + i); tick(); end
        clken = 0; Ez_n_i = 32'd999;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (fifo_count !== 7'd2 || busy !== 1'b1)
                begin n_err++; $display("FAIL clken_hold%0d: got cnt=%0d busy=%b need 2 1", i, fifo_count, busy); end
        end
        clken = 1;
        for (int i = 0; i < 4; i++) begin
            Ez_n_i = 32'(52 + i); tick();
            n_cmp++; if (done !== (i == 3)) begin n_err++; $display("FAIL clken_done%0d: got %b need %b", i, done, i == 3); end
        end
        quiet();
        for (int i = 0; i < 6; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            n_cmp++; if (rd_data !== 32'(50 + i) || rd_data !== m_rd)
                begin n_err++; $display("FAIL clken_read%0d: got %0d need %0d", i, rd_data, 50 + i); end
        end
    endtask

    task automatic test_abort();
        quiet();
        begin_run(1, 8);
        clken = 1; ez_valid = 1;
        for (int i = 0; i < 3; i++) begin Ez_n_i = 32'(200 + i); tick(); end
        abort = 1; Ez_n_i = 32'd203; tick(); quiet();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || fifo_count !== 7'd3)
            begin n_err++; $display("FAIL abort_state: got busy=%b done=%b cnt=%0d need 0 0 3", busy, done, fifo_count); end
        begin_run(1, 2);
        clken = 1; ez_valid = 1;
        for (int i = 0; i < 2; i++) begin Ez_n_i = 32'(300 + i); tick(); end
        quiet();
        n_cmp++; if (fifo_count !== 7'd5 || overflow !== 1'b0 || done !== 1'b1)
            begin n_err++; $display("FAIL abort_rerun: got cnt=%0d ovf=%b done=%b need 5 0 1", fifo_count, overflow, done); end
        for (int i = 0; i < 5; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            n_cmp++; if (rd_data !== m_rd) begin n_err++; $display("FAIL abort_read%0d: got %0d need %0d", i, rd_data, m_rd); end
        end
    endtask

    task automatic test_overflow();
        quiet();
        begin_run(1, 70);
        clken = 1; ez_valid = 1;
        for (int i = 0; i < 70; i++) begin Ez_n_i = 32'(i); tick(); end
        quiet();
        n_cmp++; if (fifo_count !== 7'd64 || overflow !== 1'b1 || done !== 1'b1)
            begin n_err++; $display("FAIL ovf_fill: got cnt=%0d ovf=%b done=%b need 64 1 1", fifo_count, overflow, done); end
        begin_run(1, 1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b need 0", overflow); end
        clken = 1; ez_valid = 1; rd_en = 1; Ez_n_i = 32'd777; tick(); quiet();
        n_cmp++; if (fifo_count !== 7'd63 || overflow !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 32'd0)
            begin n_err++; $display("FAIL ovf_pop_drop: got cnt=%0d ovf=%b rv=%b rd=%0d need 63 1 1 0", fifo_count, overflow, rd_valid, rd_data); end
        for (int i = 1; i < 64; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            n_cmp++; if (rd_data !== 32'(i)) begin n_err++; $display("FAIL ovf_read%0d: got %0d need %0d", i, rd_data, i); end
        end
        rd_en = 1; tick(); rd_en = 0;
        n_cmp++; if (rd_valid !== 1'b0 || fifo_count !== 7'd0)
            begin n_err++; $display("FAIL ovf_empty_read: got rv=%b cnt=%0d need 0 0", rd_valid, fifo_count); end
    endtask

    task automatic test_random();
        quiet();
        for (int run = 0; run < 8; run++) begin
            begin_run($urandom_range(0, 4), $urandom_range(0, 20));
            for (int c = 0; c < 50; c++) begin
                clken    = ($urandom_range(0, 3) != 0);
                ez_valid = ($urandom_range(0, 3) != 0);
                Ez_n_i   = $urandom;
                rd_en    = ($urandom_range(0, 9) < 3);
                abort    = ($urandom_range(0, 49) == 0);
                start    = ($urandom_range(0, 19) == 0);
                tick();
                n_cmp++; if (fifo_count !== 7'(m_q.size()))
                    begin n_err++; $display("FAIL rnd_count r%0d c%0d: got %0d need %0d", run, c, fifo_count, m_q.size()); end
                n_cmp++; if (busy !== (m_mode == 1) || done !== (m_mode == 2))
                    begin n_err++; $display("FAIL rnd_state r%0d c%0d: got busy=%b done=%b need mode %0d", run, c, busy, done, m_mode); end
                n_cmp++; if (overflow !== m_ovf)
                    begin n_err++; $display("FAIL rnd_ovf r%0d c%0d: got %b need %b", run, c, overflow, m_ovf); end
                n_cmp++; if (rd_valid !== m_rv || rd_data !== m_rd)
                    begin n_err++; $display("FAIL rnd_read r%0d c%0d: got v=%b %0h need v=%b %0h", run, c, rd_valid, rd_data, m_rv, m_rd); end
            end
            quiet();
        end
    endtask

    task automatic test_reset_midrun();
        quiet();
        begin_run(1, 10);
        clken = 1; ez_valid = 1;
        for (int i = 0; i < 3; i++) begin Ez_n_i = 32'(i); tick(); end
        quiet();
        RST = 1; tick(); RST = 0;
        n_cmp++; if (fifo_count !== 7'd0 || busy !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL reset_midrun: got cnt=%0d busy=%b done=%b need 0 0 0", fifo_count, busy, done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_clken();
        test_abort();
        test_overflow();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
